// File: rtl/cdp_int_sum_ctrl.sv
// cdp_int_sum_ctrl: per-layer control for the CDP squared-sum datapath (two-stage pipe, window length decode).
// Optional feature: define CDP_INT_SUM_CTRL_PERF_EN to add the perf_stall_cnt output-stall counter.
`default_nettype none

module cdp_int_sum_ctrl #(
  parameter int pBEAT_BW = 13
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic [1:0]          reg2dp_normalz_len,
  input  logic [pBEAT_BW-1:0] reg2dp_beat_num,
  input  logic                op_en,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                load_din_d,
  output logic                load_din_2d,
  output logic                len5,
  output logic                len7,
  output logic                len9,
  output logic [1:0]          cfg_len,
  output logic                op_done
`ifdef CDP_INT_SUM_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic                s1_vld_q;
  logic                s2_vld_q;
  logic                s1_vld_d;
  logic                s2_vld_d;
  logic [pBEAT_BW-1:0] cnt_q;
  logic [pBEAT_BW-1:0] limit_q;
  logic [1:0]          cfg_len_q;
  logic                len5_q;
  logic                len7_q;
  logic                len9_q;
  logic                op_done_q;

  // Stage 2 may reload in the same cycle it hands off, which keeps it full with new data.
  assign load_din_2d = s1_vld_q & (~s2_vld_q | out_rdy);
  assign in_rdy      = (state_q == RUN) & (~s1_vld_q | load_din_2d);
  assign load_din_d  = in_vld & in_rdy;
  assign s1_vld_d    = load_din_d | (s1_vld_q & ~load_din_2d);
  assign s2_vld_d    = load_din_2d | (s2_vld_q & ~out_rdy);

  assign out_vld = s2_vld_q;
  assign cfg_len = cfg_len_q;
  assign len5    = len5_q;
  assign len7    = len7_q;
  assign len9    = len9_q;
  assign op_done = op_done_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q   <= IDLE;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      cnt_q     <= '0;
      limit_q   <= '0;
      cfg_len_q <= 2'd0;
      len5_q    <= 1'b0;
      len7_q    <= 1'b0;
      len9_q    <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      len5_q    <= (cfg_len_q == 2'd1);
      len7_q    <= (cfg_len_q == 2'd2);
      len9_q    <= (cfg_len_q == 2'd3);
      op_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_en) begin
            state_q   <= RUN;
            cfg_len_q <= reg2dp_normalz_len;
            limit_q   <= reg2dp_beat_num;
            cnt_q     <= '0;
          end
        end
        RUN: begin
          // Counter stops at the limit so an all-ones limit cannot wrap.
          if (load_din_d) begin
            if (cnt_q == limit_q) begin
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + pBEAT_BW'(1);
            end
          end
        end
        DRAIN: begin
          if (!s1_vld_q && !s2_vld_q) begin
            state_q   <= DONE;
            op_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CDP_INT_SUM_CTRL_PERF_EN
  logic [31:0] perf_cnt_q;

  assign perf_stall_cnt = perf_cnt_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_cnt_q <= 32'd0;
    end else if ((state_q == IDLE) && op_en) begin
      perf_cnt_q <= 32'd0;
    end else if (s2_vld_q && !out_rdy && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdp_int_sum_ctrl.sv
// Randomized scoreboard bench for cdp_int_sum_ctrl: beats are tracked through a bench-side two-stage data model.
`default_nettype none

module tb_cdp_int_sum_ctrl;

  localparam int BW = 13;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    reg_len = 2'd0;
  logic [BW-1:0] reg_bn = '0;
  logic          op_en = 1'b0;
  logic          in_vld = 1'b0;
  logic          out_rdy = 1'b1;
  logic          in_rdy, out_vld, load_din_d, load_din_2d;
  logic          len5, len7, len9, op_done;
  logic [1:0]    cfg_len;
`ifdef CDP_INT_SUM_CTRL_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  cdp_int_sum_ctrl #(.pBEAT_BW(BW)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .reg2dp_normalz_len(reg_len),
    .reg2dp_beat_num   (reg_bn),
    .op_en             (op_en),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .load_din_d        (load_din_d),
    .load_din_2d       (load_din_2d),
    .len5              (len5),
    .len7              (len7),
    .len9              (len9),
    .cfg_len           (cfg_len),
    .op_done           (op_done)
`ifdef CDP_INT_SUM_CTRL_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    longint      c;
  } beat_t;

  beat_t       exp_q[$];
  longint      cyc = 0;
  int          passed = 0;
  int          total = 0;
  logic [15:0] in_data = 16'd0;
  logic [15:0] dp_d1 = 16'd0;
  logic [15:0] dp_d2 = 16'd0;
  logic [1:0]  exp_len = 2'd0;
  longint      exp_beats = 0;
  int          outs = 0;
  int          dones = 0;
  int          stalls = 0;
  bit          done_seen = 1'b0;
  bit          lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side datapath: stage registers driven by the controller's enables.
  always @(posedge clk) begin
    if (load_din_d)  dp_d1 <= in_data;
    if (load_din_2d) dp_d2 <= dp_d1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    beat_t e;
    if (rstn) begin
      if (out_vld && out_rdy) begin
        check("out_has_pending_beat", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data_order", dp_d2, e.d);
          if (lat_chk) check("latency", cyc - e.c, 2);
          check("len5", len5, exp_len == 2'd1);
          check("len7", len7, exp_len == 2'd2);
          check("len9", len9, exp_len == 2'd3);
        end
        outs++;
      end
      if (out_vld && !out_rdy) stalls++;
      if (op_done) begin
        dones++;
        check("beats_delivered", outs, exp_beats);
        check("scoreboard_empty", exp_q.size(), 0);
        check("op_done_count", dones, 1);
        check("cfg_len_at_done", cfg_len, exp_len);
`ifdef CDP_INT_SUM_CTRL_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, stalls);
`endif
        done_seen = 1'b1;
      end
    end
  end

  // mode 0: in_vld/out_rdy high; 1: out_rdy low for layer cycles 3-6;
  // 2: random in_vld/out_rdy; 3: out_rdy held low, returns once all beats accepted and out_vld is up.
  task automatic run_layer(input logic [1:0] len, input logic [BW-1:0] bn, input int mode, input bit disturb);
    longint sent = 0;
    int     lc = 0;
    longint guard = 0;
    longint limit;
    exp_len   = len;
    exp_beats = longint'(bn) + 1;
    outs      = 0;
    dones     = 0;
    done_seen = 1'b0;
    lat_chk   = (mode == 0);
    limit     = exp_beats * 8 + 100;
    @(posedge clk); #1;
    reg_len = len;
    reg_bn  = bn;
    op_en   = 1'b1;
    stalls  = 0;
    @(posedge clk); #1;
    op_en = 1'b0;
    check("cfg_len_latched", cfg_len, len);
    while (!done_seen && guard < limit) begin
      in_vld  = (sent < exp_beats) && ((mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data = 16'($urandom);
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = !(lc >= 3 && lc <= 6);
        3:       out_rdy = 1'b0;
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      if (disturb && sent == 2) begin
        op_en   = 1'b1;
        reg_len = ~len;
        reg_bn  = bn + BW'(3);
      end else begin
        op_en = 1'b0;
      end
      @(negedge clk);
      if (in_vld && in_rdy) begin
        exp_q.push_back('{d: in_data, c: cyc});
        sent++;
      end
      if (mode == 3 && sent == exp_beats && out_vld) break;
      @(posedge clk); #1;
      lc++;
      guard++;
    end
    op_en  = 1'b0;
    in_vld = 1'b0;
    if (mode != 3) begin
      check("op_done_timeout", done_seen, 1);
      check("beats_accepted", sent, exp_beats);
      out_rdy = 1'b1;
      @(negedge clk);
      check("op_done_single_cycle", op_done, 0);
      check("in_rdy_low_after_layer", in_rdy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_rdy"}, in_rdy, 0);
    check({tag, "_out_vld"}, out_vld, 0);
    check({tag, "_op_done"}, op_done, 0);
    check({tag, "_load_d"}, load_din_d, 0);
    check({tag, "_load_2d"}, load_din_2d, 0);
    check({tag, "_len579"}, {len5, len7, len9}, 0);
    check({tag, "_cfg_len"}, cfg_len, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_layer(2'd1, BW'(3), 0, 1'b0);
    run_layer(2'd3, BW'(7), 1, 1'b0);
    run_layer(2'd0, BW'(0), 0, 1'b0);
    run_layer(2'd2, BW'(5), 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_layer(2'($urandom_range(0, 3)), BW'($urandom_range(0, 20)), 2, 1'b0);
    end
    run_layer(2'd3, {BW{1'b1}}, 0, 1'b0);

    // Abandon a layer while stage 2 holds an unconsumed beat.
    run_layer(2'd2, BW'(0), 3, 1'b0);
    #2 rstn = 1'b0;
    #1 check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_in_reset", op_done, 0);
    end
    rstn = 1'b1;
    exp_q.delete();
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_reset", {op_done, in_rdy, out_vld}, 0);
    end
    run_layer(2'd1, BW'(4), 2, 1'b0);
    run_layer(2'd3, BW'(2), 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
